data_unpacker: RTL
==================

Name: data_unpacker

Overview:
- Inverse of the trace-path packer. Takes full N-wide packed vectors and re-emits them as slices of N, M or 1 values per beat.
- The slice size is set per chain by a firmware mode byte.
- Sits on the readback/replay side of the instrumentation. Feeds downstream blocks that expect un-packed vectors with an element count.
- Uses a valid/ready handshake on both sides. Config bytes are loaded through the shared configId/configData bus while tracing is low.

Parameters:
- N, 8: vector width in elements.
- M, 2: medium slice width in elements; 1 < M <= N.
- DATA_WIDTH, 32: bits per element.
- MAX_CHAINS, 4: number of chains, each with its own mode byte.
- PERSONAL_CONFIG_ID, 0: configId value that addresses this block.
- INITIAL_FIRMWARE, all 0: reset mode byte per chain, [7:0] x MAX_CHAINS.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- tracing  in  1  high = normal operation; low = configuration mode.
- configId  in  8  configuration target id.
- configData  in  8  configuration byte.
- valid_in  in  1  packed vector present.
- ready_in  out  1  block can accept a packed vector.
- chainId_in  in  $clog2(MAX_CHAINS)  chain of the input vector.
- vector_in  in  DATA_WIDTH x N  packed vector; element 0 is the oldest.
- vector_out  out  DATA_WIDTH x N  slice; valid elements at the low indices, unused elements zero.
- count_out  out  $clog2(N)+1  number of valid elements in vector_out.
- valid_out  out  1  slice present.
- ready_out  in  1  downstream accepts the slice.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: valid_out=0, count_out=0, vector_out all zero, buffer empty, slice index=0, byte_counter=0, firmware=INITIAL_FIRMWARE.
- Reset asserted mid-drain discards the buffered vector immediately.
- Mode byte per chain:
  - 0 = N (one slice per vector).
  - 1 = M (ceil(N/M) slices).
  - 2 = 1 (N slices).
  - Any other value = drop: the vector is accepted and discarded, with no output.
- States:
  - EMPTY: no buffered vector.
  - DRAIN: buffer holds a vector; the slice index idx is the next element to emit.
- EMPTY -> DRAIN:
  - Taken when valid_in && ready_in and the mode is 0, 1 or 2.
  - Latch vector_in, mode and chainId; idx=0.
  - The first slice appears registered: valid_out=1 in the cycle after acceptance (latency 1).
- Slice k is defined as follows:
  - It contains buffer[idx .. idx+S-1], where S is the mode size.
  - count_out = min(S, N-idx).
  - When N is not a multiple of M, the last slice is partial and its upper elements are zero.
- Slice handshake (valid_out && ready_out):
  - idx += S.
  - If idx+S >= N on that handshake, the slice was the last one and the block returns to EMPTY.
- valid_out and vector_out hold stable while valid_out && !ready_out.
- ready_in = tracing && (EMPTY || (valid_out && ready_out && last slice)).
  - This gives back-to-back acceptance, so mode 0 sustains one vector per cycle.
- When a drop-mode vector is accepted, the state stays EMPTY, valid_out is unaffected, and no output is produced.
- tracing low:
  - ready_in=0. An already-buffered vector continues to drain.
  - If configId==PERSONAL_CONFIG_ID: byte_counter increments each cycle, and bytes 0..MAX_CHAINS-1 are written to firmware[byte_counter].
  - Later bytes are ignored.
  - If configId differs, byte_counter=0.
- A new mode takes effect only on the next accepted vector. The mode latched in DRAIN is never changed mid-vector.

Optional Feature:
- Macro: DATA_UNPACKER_LAST_FLAG_EN.
- Defined: adds output port last_out (1 bit), high with valid_out on the final slice of each vector. In mode 0, last_out equals valid_out.
- Undefined: the port is absent and no extra logic is built.

Decomposition:
- Package data_unpacker_pkg holds:
  - mode encodings MODE_N=0, MODE_M=1, MODE_1=2.
  - state enum {EMPTY, DRAIN}.
  - a helper function for slice size from mode.
- One sub-module, unpacker_config_regs. It owns byte_counter and the firmware array, takes tracing/configId/configData, and outputs mode[chainId].

Test Plan:
- Mode 0, chain 0, vectors {0..7} then {8..15} on consecutive cycles with ready_out=1 -> two beats, count_out=8, vector_out={0..7} then {8..15}, ready_in high every cycle.
- Mode 1 (M=2), vector {0..7} -> 4 beats {0,1},{2,3},{4,5},{6,7} with count_out=2, upper elements zero; ready_in low until the 4th handshake.
- Mode 2, vector {10..17}, ready_out toggling 1,0,1,0 -> 8 beats 10..17 in order with count_out=1; vector_out holds stable on stall cycles.
- N=8, M=3 build, mode 1 -> slices {0,1,2},{3,4,5},{6,7} with count 3,3,2.
- Config: tracing=0, configId=0, bytes 1,2,0,7 -> firmware={1,2,0,7}; a chain-3 vector is accepted and produces no valid_out; the chain-1 vector then yields 8 single beats.
- rst_n pulsed low during beat 3 of a mode-2 drain -> valid_out=0 immediately; after release ready_in=1 and the buffer is empty.

Source files
------------

// File: rtl/data_unpacker_pkg.sv
// Shared definitions for the data unpacker: mode encodings, FSM states, slice sizing.
package data_unpacker_pkg;

  localparam logic [7:0] MODE_N = 8'd0;
  localparam logic [7:0] MODE_M = 8'd1;
  localparam logic [7:0] MODE_1 = 8'd2;

  typedef enum logic {
    EMPTY = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // Elements per slice for a mode byte; 0 marks a drop mode.
  function automatic int unsigned slice_size(input logic [7:0] mode,
                                             input int unsigned n,
                                             input int unsigned m);
    case (mode)
      MODE_N:  return n;
      MODE_M:  return m;
      MODE_1:  return 32'd1;
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/data_unpacker_if.sv
// Packed-vector input stream and sliced output stream of the data unpacker.
// DATA_UNPACKER_LAST_FLAG_EN adds last_out.
interface data_unpacker_if #(
  parameter int unsigned N          = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_CHAINS = 4
);
  import data_unpacker_pkg::*;

  localparam int unsigned CHAIN_W = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1;
  localparam int unsigned CNT_W   = $clog2(N) + 1;

  logic                           valid_in;
  logic                           ready_in;
  logic [CHAIN_W-1:0]             chainId_in;
  logic [N-1:0][DATA_WIDTH-1:0]   vector_in;
  logic [N-1:0][DATA_WIDTH-1:0]   vector_out;
  logic [CNT_W-1:0]               count_out;
  logic                           valid_out;
  logic                           ready_out;
`ifdef DATA_UNPACKER_LAST_FLAG_EN
  logic                           last_out;

  modport slave (input valid_in, chainId_in, vector_in, ready_out,
                 output ready_in, vector_out, count_out, valid_out, last_out);
  modport master (output valid_in, chainId_in, vector_in, ready_out,
                  input ready_in, vector_out, count_out, valid_out, last_out);
`else
  modport slave (input valid_in, chainId_in, vector_in, ready_out,
                 output ready_in, vector_out, count_out, valid_out);
  modport master (output valid_in, chainId_in, vector_in, ready_out,
                  input ready_in, vector_out, count_out, valid_out);
`endif

endinterface

// File: rtl/unpacker_config_regs.sv
// Per-chain firmware mode bytes loaded over the shared config bus while tracing is low.
module unpacker_config_regs
  import data_unpacker_pkg::*;
#(
  parameter int unsigned             MAX_CHAINS         = 4,
  parameter logic [7:0]              PERSONAL_CONFIG_ID = 8'd0,
  parameter logic [MAX_CHAINS*8-1:0] INITIAL_FIRMWARE   = '0,
  localparam int unsigned            CHAIN_W = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tracing,
  input  logic [7:0]         configId,
  input  logic [7:0]         configData,
  input  logic [CHAIN_W-1:0] chain_sel,
  output logic [7:0]         mode_c
);

  logic [7:0] byte_counter;
  logic [7:0] firmware [MAX_CHAINS];
  logic       cfg_hit;

  assign cfg_hit = !tracing && (configId == PERSONAL_CONFIG_ID);

  // Byte position within a config session; saturates so late bytes never wrap onto chain 0.
  // Any cycle not addressed to this block (including tracing) restarts the session.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_counter <= '0;
    end else if (cfg_hit) begin
      if (byte_counter != 8'hFF) byte_counter <= byte_counter + 8'd1;
    end else begin
      byte_counter <= '0;
    end
  end

  // Mode bytes: the first MAX_CHAINS bytes of a session land in chain order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(MAX_CHAINS); i++) firmware[i] <= INITIAL_FIRMWARE[i*8 +: 8];
    end else if (cfg_hit && (32'(byte_counter) < MAX_CHAINS)) begin
      firmware[CHAIN_W'(byte_counter)] <= configData;
    end
  end

  assign mode_c = firmware[chain_sel];

endmodule

// File: rtl/data_unpacker.sv
// Re-emits packed N-element vectors as slices of N, M or 1 elements per beat.
// Optional macro DATA_UNPACKER_LAST_FLAG_EN adds last_out on the final slice.
module data_unpacker
  import data_unpacker_pkg::*;
#(
  parameter int unsigned             N                  = 8,
  parameter int unsigned             M                  = 2,
  parameter int unsigned             DATA_WIDTH         = 32,
  parameter int unsigned             MAX_CHAINS         = 4,
  parameter logic [7:0]              PERSONAL_CONFIG_ID = 8'd0,
  parameter logic [MAX_CHAINS*8-1:0] INITIAL_FIRMWARE   = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           tracing,
  input  logic [7:0]     configId,
  input  logic [7:0]     configData,
  data_unpacker_if.slave bus
);

  localparam int unsigned SEL_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned IDX_W = $clog2(N) + 1;
  localparam int unsigned CNT_W = $clog2(N) + 1;

  typedef logic [N-1:0][DATA_WIDTH-1:0] vec_t;

  state_e           state_q, state_d;
  vec_t             buf_q, buf_d;
  logic [7:0]       mode_q, mode_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  vec_t             vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef DATA_UNPACKER_LAST_FLAG_EN
  logic             last_q, last_d;
`endif

  logic [7:0]  mode_in_c;
  int unsigned size_cur, size_in, next_idx;
  logic        last_c, hs_c, ready_in_c, accept_c;

  // Slice of src starting at element start; elements past the slice or the vector are zero.
  function automatic vec_t make_slice(input vec_t src, input int unsigned start,
                                      input int unsigned size);
    vec_t r;
    r = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if ((i < size) && (start + i < N)) r[SEL_W'(i)] = src[SEL_W'(start + i)];
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] slice_count(input int unsigned start,
                                                   input int unsigned size);
    return (N - start < size) ? CNT_W'(N - start) : CNT_W'(size);
  endfunction

  unpacker_config_regs #(
    .MAX_CHAINS        (MAX_CHAINS),
    .PERSONAL_CONFIG_ID(PERSONAL_CONFIG_ID),
    .INITIAL_FIRMWARE  (INITIAL_FIRMWARE)
  ) u_cfg (
    .clk       (clk),
    .rst_n     (rst_n),
    .tracing   (tracing),
    .configId  (configId),
    .configData(configData),
    .chain_sel (bus.chainId_in),
    .mode_c    (mode_in_c)
  );

  // State, buffer and registered output slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      buf_q   <= '0;
      mode_q  <= MODE_N;
      idx_q   <= '0;
      valid_q <= 1'b0;
      vec_q   <= '0;
      cnt_q   <= '0;
`ifdef DATA_UNPACKER_LAST_FLAG_EN
      last_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
`ifdef DATA_UNPACKER_LAST_FLAG_EN
      last_q  <= last_d;
`endif
    end
  end

  // Next slice on handshake; a new vector can load on the same edge as the last slice leaves.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
`ifdef DATA_UNPACKER_LAST_FLAG_EN
    last_d  = last_q;
`endif

    size_cur   = slice_size(mode_q, N, M);
    size_in    = slice_size(mode_in_c, N, M);
    next_idx   = 32'(idx_q) + size_cur;
    last_c     = (next_idx >= N);
    hs_c       = valid_q && bus.ready_out;
    ready_in_c = tracing && ((state_q == EMPTY) || (hs_c && last_c));
    accept_c   = ready_in_c && bus.valid_in;

    if (hs_c) begin
      if (last_c) begin
        state_d = EMPTY;
        valid_d = 1'b0;
        vec_d   = '0;
        cnt_d   = '0;
`ifdef DATA_UNPACKER_LAST_FLAG_EN
        last_d  = 1'b0;
`endif
      end else begin
        idx_d = IDX_W'(next_idx);
        vec_d = make_slice(buf_q, next_idx, size_cur);
        cnt_d = slice_count(next_idx, size_cur);
`ifdef DATA_UNPACKER_LAST_FLAG_EN
        last_d = (next_idx + size_cur >= N);
`endif
      end
    end

    // Drop-mode vectors are consumed here with no effect on the state.
    if (accept_c && (size_in != 0)) begin
      state_d = DRAIN;
      buf_d   = bus.vector_in;
      mode_d  = mode_in_c;
      idx_d   = '0;
      valid_d = 1'b1;
      vec_d   = make_slice(bus.vector_in, 0, size_in);
      cnt_d   = slice_count(0, size_in);
`ifdef DATA_UNPACKER_LAST_FLAG_EN
      last_d  = (size_in >= N);
`endif
    end
  end

  assign bus.ready_in   = ready_in_c;
  assign bus.valid_out  = valid_q;
  assign bus.vector_out = vec_q;
  assign bus.count_out  = cnt_q;
`ifdef DATA_UNPACKER_LAST_FLAG_EN
  assign bus.last_out   = last_q;
`endif

endmodule
